// File: rtl/ifu_pkg.sv
// ifu_pkg: shared FSM encoding and constants for the instruction fetch unit
package ifu_pkg;
  localparam logic [1:0] S_REQ = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/ifu.sv
// ifu: single-outstanding instruction fetch FSM with redirect and drop handling
module ifu
  import ifu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [WIDTH-1:0] req_addr,
  input  logic             rsp_valid,
  input  logic [31:0]      rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] pc,
  output logic [31:0]      inst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [63:0]      fetch_cnt
);
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic drop_q, drop_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rdr_pc;
  logic discard;
  assign rdr_pc = redirect_pc & ~WIDTH'(3);
  assign discard = drop_q | redirect_valid;
  assign req_valid = rst & (state_q == S_REQ);
  assign req_addr = pc_q;
  assign inst_valid = state_q == S_VALID;
  assign pc = pc_q;
  assign inst = inst_q;
  assign fetch_cnt = cnt_q;
  // next-state: a redirect always reloads the pc; in flight data is dropped
  always_comb begin
    state_d = state_q;
    pc_d = redirect_valid ? rdr_pc : pc_q;
    drop_d = drop_q;
    inst_d = inst_q;
    cnt_d = cnt_q;
    if (state_q == S_REQ) begin
      if (req_valid && req_ready) begin
        state_d = S_WAIT;
        drop_d = redirect_valid;
      end
    end else if (state_q == S_WAIT) begin
      if (rsp_valid) begin
        state_d = discard ? S_REQ : S_VALID;
        drop_d = 1'b0;
        inst_d = discard ? inst_q : rsp_data;
      end else begin
        drop_d = discard;
      end
    end else if (state_q == S_VALID) begin
      if (redirect_valid || inst_ready) state_d = S_REQ;
      if (!redirect_valid && inst_ready) begin
        pc_d = pc_q + WIDTH'(4);
        cnt_d = cnt_q + 64'd1;
      end
    end else begin
      state_d = S_REQ;
    end
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_REQ;
      pc_q <= RESET_PC;
      drop_q <= 1'b0;
      inst_q <= NOP;
      cnt_q <= 64'd0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      drop_q <= drop_d;
      inst_q <= inst_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: scoreboard bench for the instruction fetch unit
module tb_ifu;
  typedef struct {
    logic [63:0] a;
    logic [31:0] w;
  } ent_t;
  logic clk, rst, req_valid, req_ready, rsp_valid, inst_valid, inst_ready, redirect_valid;
  logic [63:0] req_addr, pc, redirect_pc, fetch_cnt;
  logic [31:0] rsp_data, inst;
  int n_cmp = 0;
  int n_err = 0;
  bit auto_mem = 0;
  logic pend;
  logic [63:0] paddr;
  logic [63:0] snap_pc;
  logic [31:0] snap_inst;
  logic [63:0] addr_q[$];
  ent_t exp_q[$];
  ifu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .pc(pc), .inst(inst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_cnt(fetch_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h0bad_f00d;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic want(input logic [63:0] a, input bit deliver);
    ent_t e;
    e.a = a;
    e.w = mem_word(a);
    addr_q.push_back(a);
    if (deliver) exp_q.push_back(e);
  endtask
  task automatic tick();
    ent_t e;
    if (req_valid && req_ready && addr_q.size() != 0) chk("req_addr", req_addr, addr_q.pop_front());
    if (inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      else begin
        e = exp_q.pop_front();
        chk("deliver_pc", pc, e.a);
        chk("deliver_inst", 64'(inst), 64'(e.w));
      end
    end
    pend = req_valid && req_ready;
    paddr = req_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      rsp_valid = pend;
      rsp_data = mem_word(paddr);
    end
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    clk = 0; rst = 0; req_ready = 0; rsp_valid = 0; rsp_data = 0;
    inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_cnt", fetch_cnt, 64'd0);
    chk("rst_pc", req_addr, 64'h8000_0000);
    chk("rst_inst", 64'(inst), 64'h13);
    rst = 1;
    #1;
    chk("release_req_valid", 64'(req_valid), 64'd1);
    req_ready = 1; inst_ready = 1; auto_mem = 1;
    for (int i = 0; i < 3; i++) want(64'h8000_0000 + 64'(4 * i), 1);
    ticks(9);
    chk("cnt_after_9", fetch_cnt, 64'd3);
    inst_ready = 0;
    want(64'h8000_000C, 0);
    ticks(2);
    chk("stall_pc", pc, 64'h8000_000C);
    chk("stall_inst", 64'(inst), 64'(mem_word(64'h8000_000C)));
    snap_pc = pc;
    snap_inst = inst;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_pc_hold", pc, snap_pc);
      chk("stall_inst_hold", 64'(inst), 64'(snap_inst));
      chk("stall_req_valid", 64'(req_valid), 64'd0);
      chk("stall_inst_valid", 64'(inst_valid), 64'd1);
    end
    exp_q.push_back('{64'h8000_000C, mem_word(64'h8000_000C)});
    inst_ready = 1;
    tick();
    chk("cnt_after_stall", fetch_cnt, 64'd4);
    auto_mem = 0; rsp_valid = 0;
    want(64'h8000_0010, 0);
    tick();
    redirect_valid = 1; redirect_pc = 64'h8000_0100;
    tick();
    redirect_valid = 0; rsp_valid = 1; rsp_data = 32'h0000_0073;
    tick();
    rsp_valid = 0;
    chk("wait_rdr_req_valid", 64'(req_valid), 64'd1);
    chk("wait_rdr_addr", req_addr, 64'h8000_0100);
    chk("wait_rdr_inst_valid", 64'(inst_valid), 64'd0);
    chk("wait_rdr_cnt", fetch_cnt, 64'd4);
    auto_mem = 1;
    want(64'h8000_0100, 1);
    ticks(3);
    chk("cnt_after_rdr", fetch_cnt, 64'd5);
    inst_ready = 0;
    want(64'h8000_0104, 0);
    ticks(2);
    redirect_valid = 1; redirect_pc = 64'h8000_0203; inst_ready = 1;
    tick();
    redirect_valid = 0; inst_ready = 0;
    chk("valid_rdr_addr", req_addr, 64'h8000_0200);
    chk("valid_rdr_req_valid", 64'(req_valid), 64'd1);
    chk("valid_rdr_inst_valid", 64'(inst_valid), 64'd0);
    chk("valid_rdr_cnt", fetch_cnt, 64'd5);
    inst_ready = 1;
    want(64'h8000_0200, 0);
    redirect_valid = 1; redirect_pc = 64'h8000_0400;
    tick();
    redirect_valid = 0;
    tick();
    chk("hs_rdr_addr", req_addr, 64'h8000_0400);
    chk("hs_rdr_req_valid", 64'(req_valid), 64'd1);
    chk("hs_rdr_inst_valid", 64'(inst_valid), 64'd0);
    chk("hs_rdr_cnt", fetch_cnt, 64'd5);
    req_ready = 0;
    redirect_valid = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 0;
    chk("req_rdr_valid", 64'(req_valid), 64'd1);
    chk("req_rdr_addr", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    req_ready = 1;
    want(64'hFFFF_FFFF_FFFF_FFFC, 1);
    ticks(3);
    chk("wrap_addr", req_addr, 64'd0);
    chk("wrap_cnt", fetch_cnt, 64'd6);
    auto_mem = 0;
    want(64'd0, 0);
    tick();
    rst = 0;
    #1;
    chk("midrst_req_valid", 64'(req_valid), 64'd0);
    chk("midrst_inst_valid", 64'(inst_valid), 64'd0);
    chk("midrst_cnt", fetch_cnt, 64'd0);
    chk("midrst_pc", pc, 64'h8000_0000);
    chk("midrst_inst", 64'(inst), 64'h13);
    tick();
    rst = 1; req_ready = 0; rsp_valid = 1; rsp_data = 32'h0000_0073;
    tick();
    rsp_valid = 0;
    chk("late_rsp_req_valid", 64'(req_valid), 64'd1);
    chk("late_rsp_addr", req_addr, 64'h8000_0000);
    chk("late_rsp_inst_valid", 64'(inst_valid), 64'd0);
    chk("late_rsp_inst", 64'(inst), 64'h13);
    tick();
    chk("late_rsp_inst_valid2", 64'(inst_valid), 64'd0);
    chk("addr_q_left", 64'(addr_q.size()), 64'd0);
    chk("exp_q_left", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the PC and address width.
REQ-002 The block SHALL have parameter RESET_PC, default 64'h8000_0000, giving the first fetch address.
REQ-003 The block SHALL have port clk  input  1  as its single clock; every flop is rising-edge.
REQ-004 The block SHALL have port rst  input  1  as its asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid  output  1  meaning the fetch request to instruction memory is valid.
REQ-006 The block SHALL have port req_ready  input  1  meaning memory accepts the request.
REQ-007 The block SHALL have port req_addr  output  WIDTH  giving the fetch address.
REQ-008 The block SHALL have port rsp_valid  input  1  meaning the memory response is valid; it is always accepted.
REQ-009 The block SHALL have port rsp_data  input  32  carrying the fetched instruction word.
REQ-010 The block SHALL have port inst_valid  output  1  meaning pc and inst are offered to the decoder.
REQ-011 The block SHALL have port inst_ready  input  1  meaning the decoder/execute stage consumes the offer.
REQ-012 The block SHALL have port pc  output  WIDTH  giving the address of the offered instruction.
REQ-013 The block SHALL have port inst  output  32  giving the offered instruction word.
REQ-014 The block SHALL have port redirect_valid  input  1  meaning a taken branch or jump was resolved.
REQ-015 The block SHALL have port redirect_pc  input  WIDTH  giving the branch or jump target.
REQ-016 The block SHALL have port fetch_cnt  output  64  counting the instructions delivered.

Function
REQ-017 The block SHALL implement the FSM states REQ, WAIT and VALID, with at most one request outstanding.
REQ-018 In state REQ: req_valid=1 and req_addr=fetch_pc; on req_valid&req_ready the FSM SHALL move to WAIT.
REQ-019 While in REQ and not yet accepted, req_addr may change; the memory side tolerates request retraction.
REQ-020 In state WAIT: req_valid=0; on rsp_valid with drop=0 the block SHALL latch inst<=rsp_data and move to VALID.
REQ-021 In state WAIT: on rsp_valid with drop=1 the block SHALL discard the data, clear drop, and move to REQ.
REQ-022 In state VALID: inst_valid=1 and pc/inst held stable; on inst_ready the block SHALL set fetch_pc<=fetch_pc+4, increment fetch_cnt, and move to REQ.
REQ-023 Minimum latency from request accept to inst_valid SHALL be 1 cycle after rsp_valid, i.e. a zero-wait memory yields one instruction per 3 cycles.
REQ-024 A redirect in REQ with no handshake SHALL load fetch_pc<=redirect_pc and keep the FSM in REQ.
REQ-025 A redirect in REQ on the same cycle as a handshake SHALL load fetch_pc, set drop=1, and move to WAIT.
REQ-026 A redirect in WAIT SHALL load fetch_pc and set drop=1; if rsp_valid arrives on the same cycle, that response is discarded and the FSM moves to REQ.
REQ-027 A redirect in VALID SHALL load fetch_pc, deassert inst_valid the next cycle, and move to REQ; it wins over a simultaneous inst_ready, which then neither increments fetch_cnt nor adds 4.
REQ-028 Bits [1:0] of redirect_pc SHALL be forced to 0 on load.
REQ-029 PC arithmetic SHALL be modulo 2^WIDTH, so all-ones minus 3 plus 4 wraps to 0.
REQ-030 fetch_cnt SHALL wrap at 2^64.

Reset
REQ-031 Asserting rst (low), at any time including while a request is in flight, SHALL immediately force: state=REQ, fetch_pc=RESET_PC, drop=0, inst=32'h0000_0013 (NOP), fetch_cnt=0, inst_valid=0.
REQ-032 req_valid SHALL be 0 while rst is asserted and SHALL be 1 on the first clk edge after release.
REQ-033 A response for a request that was pending across reset SHALL be ignored, because the FSM is in REQ after reset.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, RESET_PC default and the NOP constant.
REQ-035 The block SHALL be a single module with no sub-module.

Verification
REQ-036 The bench SHALL cover: reset release with zero-wait memory and inst_ready=1 -> req_addr 8000_0000, 8000_0004, 8000_0008 and fetch_cnt=3 after 9 cycles.
REQ-037 The bench SHALL cover: inst_ready=0 for 5 cycles in VALID -> pc/inst stable and req_valid=0 throughout.
REQ-038 The bench SHALL cover: redirect_pc=8000_0100 in WAIT, then rsp_valid with 0x00000073 -> data dropped, next req_addr=8000_0100.
REQ-039 The bench SHALL cover: redirect_pc=8000_0203 together with inst_ready in VALID -> next req_addr=8000_0200 and fetch_cnt unchanged.
REQ-040 The bench SHALL cover: rst asserted low mid-WAIT -> outputs at reset values immediately, and a late rsp_valid is ignored.
REQ-041 The bench SHALL cover: WIDTH=64 with fetch_pc=FFFF_FFFF_FFFF_FFFC, delivered -> next req_addr=0.
